// File: rtl/rr_mux_arbiter.sv
// Four-source round-robin arbiter with bounded hold time; the registered select
// steers a shared 4:1 single-bit data mux.
module rr_mux_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       y
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_reg, state_next;
  logic [3:0] gnt_reg, gnt_next;
  logic [1:0] sel_reg, sel_next;
  logic       valid_reg, valid_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [3:0] hold_cnt_reg, hold_cnt_next;

  logic [3:0] rot_req;
  logic [1:0] win_off;
  logic [1:0] win_idx;
  logic       any_req;
  logic       holder_req;
  logic       other_req;
  logic       rearb;
  logic       release_grant;

  // Requests rotated so that bit 0 is the source the pointer currently favours.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      logic [1:0] idx;
      assign idx         = ptr_reg + 2'(gi);
      assign rot_req[gi] = req[idx];
    end
  endgenerate

  always_comb begin
    win_off = '0;
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) win_off = 2'(i);
    end
  end

  assign win_idx    = ptr_reg + win_off;
  assign any_req    = |req;
  assign holder_req = req[sel_reg];
  assign other_req  = |(req & ~gnt_reg);

  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    sel_next      = sel_reg;
    valid_next    = valid_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    rearb         = 1'b0;
    release_grant = 1'b0;

    case (state_reg)
      IDLE: begin
        if (any_req) rearb = 1'b1;
        else         release_grant = 1'b1;
      end
      GRANT: begin
        if (holder_req) begin
          if (hold_cnt_reg < HOLD_LAST) hold_cnt_next = hold_cnt_reg + 4'd1;
          else if (other_req)           rearb = 1'b1;
          else                          hold_cnt_next = '0;
        end else if (any_req) begin
          rearb = 1'b1;
        end else begin
          release_grant = 1'b1;
        end
      end
      default: release_grant = 1'b1;
    endcase

    // The pointer sits just past the holder, so a forced hand-off never re-picks it.
    if (rearb) begin
      state_next    = GRANT;
      gnt_next      = 4'b0001 << win_idx;
      sel_next      = win_idx;
      valid_next    = 1'b1;
      ptr_next      = win_idx + 2'd1;
      hold_cnt_next = '0;
    end

    if (release_grant) begin
      state_next    = IDLE;
      gnt_next      = '0;
      valid_next    = 1'b0;
      hold_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      sel_reg      <= '0;
      valid_reg    <= 1'b0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      sel_reg      <= sel_next;
      valid_reg    <= valid_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  assign gnt   = gnt_reg;
  assign sel   = sel_reg;
  assign valid = valid_reg;
  assign y     = valid_reg & din[sel_reg];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench: the driver queues hand-computed post-edge outputs, the monitor
// pops and compares them, then checks invariants, fairness and rotation under random traffic.
module tb_rr_mux_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] din = '0;
  logic [3:0] gnt, gnt1;
  logic [1:0] sel, sel1;
  logic       valid, valid1, y, y1;

  rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .valid(valid), .y(y)
  );

  rr_mux_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt1), .sel(sel1), .valid(valid1), .y(y1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       y;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Inputs change on the falling edge; the entry describes outputs after the next rising edge.
  task automatic vec(input logic r, input logic [3:0] rq, input logic [3:0] d,
                     input logic [3:0] eg, input logic [1:0] es, input logic ev,
                     input logic ey, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; din = d;
    e.gnt = eg; e.sel = es; e.valid = ev; e.y = ey; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t       e;
    int         wait_cnt [4];
    logic [3:0] prev_gnt1;
    logic       prev_valid1;
    for (int n = 0; n < 4; n++) wait_cnt[n] = 0;
    prev_gnt1   = '0;
    prev_valid1 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, "_gnt"},   gnt,   e.gnt);
        check({e.name, "_sel"},   sel,   e.sel);
        check({e.name, "_valid"}, valid, e.valid);
        check({e.name, "_y"},     y,     e.y);
        $display("txn %-14s rst=%b req=%b din=%b -> gnt=%b sel=%0d valid=%b y=%b",
                 e.name, rst, req, din, gnt, sel, valid, y);
      end
      check("onehot0", $onehot0(gnt), 1);
      check("valid_vs_gnt", valid, |gnt);
      if (valid === 1'b1) check("sel_matches_gnt", gnt, 4'b0001 << sel);
      check("y_mux", y, valid & din[sel]);
      if (rand_phase) begin
        for (int n = 0; n < 4; n++) begin
          if (req[n] && !gnt[n]) wait_cnt[n]++;
          else                   wait_cnt[n] = 0;
          check($sformatf("fair_wait_src%0d", n), wait_cnt[n] <= 3 * MAX_HOLD, 1);
        end
        if (prev_valid1 && $countones(req) >= 2)
          check("hold1_rotates", gnt1 != prev_gnt1, 1);
      end
      prev_gnt1   = gnt1;
      prev_valid1 = valid1;
    end
  end

  // Driver
  initial begin
    // Reset with all requests held, then full round-robin rotation.
    vec(1, 4'hF, 4'b1010, 4'b0000, 2'd0, 0, 0, "rst_hold");
    vec(1, 4'hF, 4'b1010, 4'b0000, 2'd0, 0, 0, "rst_hold");
    vec(0, 4'hF, 4'b1010, 4'b0001, 2'd0, 1, 0, "rr_first");
    repeat (3) vec(0, 4'hF, 4'b1010, 4'b0001, 2'd0, 1, 0, "rr_src0");
    repeat (4) vec(0, 4'hF, 4'b1010, 4'b0010, 2'd1, 1, 1, "rr_src1");
    repeat (4) vec(0, 4'hF, 4'b1010, 4'b0100, 2'd2, 1, 0, "rr_src2");
    repeat (4) vec(0, 4'hF, 4'b1010, 4'b1000, 2'd3, 1, 1, "rr_src3");
    vec(0, 4'hF, 4'b1010, 4'b0001, 2'd0, 1, 0, "rr_wrap");

    // Two contenders alternate every MAX_HOLD cycles.
    vec(1, 4'b0101, 4'b0100, 4'b0000, 2'd0, 0, 0, "rst_b");
    repeat (4) vec(0, 4'b0101, 4'b0100, 4'b0001, 2'd0, 1, 0, "alt_src0");
    repeat (4) vec(0, 4'b0101, 4'b0100, 4'b0100, 2'd2, 1, 1, "alt_src2");
    repeat (4) vec(0, 4'b0101, 4'b0100, 4'b0001, 2'd0, 1, 0, "alt_src0b");

    // Lone requester keeps the grant across the hold boundary; idle keeps sel.
    vec(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, "rst_c");
    repeat (10) vec(0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1, 1, "solo3");
    vec(0, 4'b0000, 4'b1000, 4'b0000, 2'd3, 0, 0, "drop_idle");
    vec(0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 0, 0, "idle_sel_kept");

    // Holder drops while another waits: direct hand-off, pointer wraps to 0.
    vec(0, 4'b0010, 4'b1111, 4'b0010, 2'd1, 1, 1, "hold1");
    vec(0, 4'b1000, 4'b1111, 4'b1000, 2'd3, 1, 1, "handoff3");
    vec(0, 4'b0011, 4'b1111, 4'b0001, 2'd0, 1, 1, "ptr_after3");

    // Reset in the middle of a grant.
    vec(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0, "rst_e");
    vec(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, "src2_h0");
    vec(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, "src2_h1");
    vec(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, "src2_h2");
    vec(1, 4'b0100, 4'b0100, 4'b0000, 2'd0, 0, 0, "rst_midgrant");
    vec(0, 4'b0110, 4'b0010, 4'b0010, 2'd1, 1, 1, "post_rst_src1");

    // Random traffic, checked by invariants only.
    @(negedge clk);
    rand_phase = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = 4'hF;
      din = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    rand_phase = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
Parameters (name, default, meaning)
REQ-001 The block SHALL have parameter MAX_HOLD, default 4: maximum consecutive grant cycles per holder while others wait; legal range 1..15.

Ports (name  direction  width  meaning)
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 The block SHALL have port req  input  4  request per source; bit n requests source n.
REQ-005 The block SHALL have port din  input  4  1-bit data per source; bit n is the data for source n.
REQ-006 The block SHALL have port gnt  output  4  one-hot grant, registered; all zero when idle.
REQ-007 The block SHALL have port sel  output  2  registered binary index of the granted source; drives the shared 4:1 mux.
REQ-008 The block SHALL have port valid  output  1  registered; high exactly when gnt is nonzero.
REQ-009 The block SHALL have port y  output  1  combinational; din[sel] when valid=1, else 0.
REQ-010 The block SHALL have one clock and a synchronous, active-high reset; clk and rst SHALL be the only clock and reset.

Function
REQ-011 The FSM SHALL have states IDLE (no grant) and GRANT (one holder); state SHALL be encoded internally and not exported.
REQ-012 The block SHALL keep a 2-bit round-robin pointer ptr; the search order SHALL be ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first requesting source SHALL win.
REQ-013 On each new grant to source n, ptr SHALL become (n+1) mod 4 at the same edge.
REQ-014 IDLE, req=0 at the edge: the block SHALL stay in IDLE with gnt=0, valid=0, and sel unchanged.
REQ-015 IDLE, req!=0 at edge k: after edge k, gnt, sel, and valid=1 SHALL reflect the winner; state SHALL go to GRANT and hold_cnt SHALL be 0 (one-cycle latency from req to gnt).
REQ-016 GRANT, holder req=1, hold_cnt<MAX_HOLD-1: the grant SHALL be kept and hold_cnt SHALL be incremented.
REQ-017 GRANT, holder req=1, hold_cnt=MAX_HOLD-1, another req bit set: the block SHALL re-arbitrate from ptr at the same edge (no idle bubble), the new holder SHALL differ from the old one, and hold_cnt SHALL be set to 0.
REQ-018 GRANT, holder req=1, hold_cnt=MAX_HOLD-1, no other req: the holder SHALL keep the grant and hold_cnt SHALL be set to 0.
REQ-019 GRANT, holder req=0, another req set: the block SHALL re-arbitrate from ptr at the same edge with no bubble, and hold_cnt SHALL be set to 0.
REQ-020 GRANT, req=0: the block SHALL go to IDLE at the next edge with gnt=0 and valid=0; sel SHALL keep its last value.
REQ-021 hold_cnt SHALL be 4 bits wide and SHALL never exceed MAX_HOLD-1.
REQ-022 With MAX_HOLD=1, the grant SHALL rotate every cycle while two or more sources request.
REQ-023 gnt SHALL always be one-hot or zero; sel SHALL equal the index of the set gnt bit whenever valid=1.
REQ-024 Fairness: with all four req bits held high, each source SHALL be granted within 3*MAX_HOLD cycles of losing arbitration.
REQ-025 Changes to req or din between edges SHALL NOT affect gnt, sel, or valid until the next edge; y SHALL follow din combinationally.

Reset
REQ-026 With rst=1 at an edge, that edge SHALL set state=IDLE, gnt=0, sel=2'b00, valid=0, ptr=0, and hold_cnt=0; y SHALL then read 0.
REQ-027 Reset SHALL have priority over all other inputs, including mid-grant; the first arbitration after reset SHALL start from source 0.

Verification
REQ-028 Reset with req=4'b1111 held -> gnt=0 during reset; first edge after reset gives gnt=4'b0001, sel=0, valid=1.
REQ-029 MAX_HOLD=4, req=4'b0101 held, din=4'b0100 -> source 0 granted for 4 cycles (y=0), then source 2 for 4 cycles (y=1), alternating.
REQ-030 Single req=4'b1000 held 10 cycles -> gnt=4'b1000 throughout with no drop at the hold boundary; req=0 -> next edge gives valid=0, sel stays 3.
REQ-031 Holder 1 drops req while req[3]=1 -> next edge gives gnt=4'b1000 with no idle cycle and ptr=0.
REQ-032 rst pulsed mid-grant (holder 2, hold_cnt=2) -> next edge gives all outputs at reset values; with req=4'b0110 afterwards, source 1 wins.
REQ-033 Random req/din for 2000 cycles -> checker confirms REQ-023, REQ-024, and y==din[sel]&valid every cycle.
